// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display path.
// Used by the binary-to-BCD feeder and the 8-digit scanner.
package seg7_pkg;

  localparam int unsigned AN_NUM  = 8;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [3:0] DIGIT_BLANK = 4'hA;
  localparam logic [3:0] DIGIT_MINUS = 4'hF;

  localparam logic [31:0] MAX_POS     = 32'd99_999_999;
  localparam logic [31:0] MAX_NEG_MAG = 32'd9_999_999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREP   = 2'd1,
    SHIFT  = 2'd2,
    FORMAT = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is >= 5.
// Ports: d - BCD nibble in; q - corrected nibble out.
module bcd_add3
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  assign q = (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;

endmodule

// File: rtl/seg7_bin2bcd.sv
// Sequential signed binary to packed 8-digit display-code converter.
// One double-dabble shift per clock; result held on num_o between conversions.
// Ports:
//   clk_i   - clock
//   rst     - synchronous active-high reset
//   value_i - signed 32-bit value, latched on accept
//   valid_i - request, accepted when valid_i & ready_o at a rising edge
//   ready_o - converter idle
//   num_o   - eight 4-bit digit codes, digit 0 in bits [3:0]
//   done_o  - one-cycle pulse when num_o/ovf_o update
//   ovf_o   - last accepted value was out of range
module seg7_bin2bcd
  import seg7_pkg::*;
#(
  parameter bit          BLANK_LZ = 1'b1,
  parameter int unsigned MAG_W    = 27
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic [31:0] value_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] num_o,
  output logic        done_o,
  output logic        ovf_o
);

  localparam int unsigned BCD_W = AN_NUM * DIGIT_W;
  localparam int unsigned CNT_W = $clog2(MAG_W);

  state_t             state_q;
  logic [31:0]        val_q;
  logic               neg_q;
  logic               range_ovf_q;
  logic [MAG_W-1:0]   mag_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               val_neg;
  logic [31:0]        abs_val;
  logic               range_ovf;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   fmt_word;
  logic [3:0]         ms_idx;

  assign ready_o = (state_q == IDLE) && !rst;

  // Magnitude and range check; abs(-2^31) stays 2^31 as unsigned and fails the check.
  assign val_neg   = val_q[31];
  assign abs_val   = val_neg ? (~val_q + 32'd1) : val_q;
  assign range_ovf = val_neg ? (abs_val > MAX_NEG_MAG) : (abs_val > MAX_POS);

  // Add-3 correction on every BCD nibble before each shift.
  for (genvar g = 0; g < AN_NUM; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .q (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Final display word: leading-zero blanking, minus placement, overflow dashes.
  always_comb begin
    fmt_word = bcd_q;
    ms_idx   = 4'd0;
    for (int k = 0; k < AN_NUM; k++) begin
      if (bcd_q[k*DIGIT_W +: DIGIT_W] != '0) ms_idx = 4'(k);
    end
    if (BLANK_LZ) begin
      for (int k = 0; k < AN_NUM; k++) begin
        if (4'(k) > ms_idx) fmt_word[k*DIGIT_W +: DIGIT_W] = DIGIT_BLANK;
        if (neg_q && (4'(k) == ms_idx + 4'd1)) fmt_word[k*DIGIT_W +: DIGIT_W] = DIGIT_MINUS;
      end
    end else if (neg_q) begin
      fmt_word[BCD_W-1 -: DIGIT_W] = DIGIT_MINUS;
    end
    if (range_ovf_q) fmt_word = {AN_NUM{DIGIT_MINUS}};
  end

  // Converter FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q     <= IDLE;
      val_q       <= '0;
      neg_q       <= 1'b0;
      range_ovf_q <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      num_o       <= {AN_NUM{DIGIT_BLANK}};
      done_o      <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            val_q   <= value_i;
            state_q <= PREP;
          end
        end
        PREP: begin
          neg_q       <= val_neg;
          range_ovf_q <= range_ovf;
          mag_q       <= abs_val[MAG_W-1:0];
          bcd_q       <= '0;
          cnt_q       <= '0;
          state_q     <= SHIFT;
        end
        SHIFT: begin
          {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
          cnt_q          <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAG_W - 1)) state_q <= FORMAT;
        end
        FORMAT: begin
          num_o   <= fmt_word;
          ovf_o   <= range_ovf_q;
          done_o  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_bin2bcd.sv
// Self-checking bench for seg7_bin2bcd: one instance per BLANK_LZ setting,
// results compared against a decimal-arithmetic reference model.
module tb_seg7_bin2bcd;

  logic        clk_i = 1'b0;
  logic        rst   = 1'b1;

  logic [31:0] value1 = '0, value0 = '0;
  logic        valid1 = 1'b0, valid0 = 1'b0;
  logic        ready1, ready0;
  logic [31:0] num1, num0;
  logic        done1, done0;
  logic        ovf1, ovf0;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  seg7_bin2bcd #(.BLANK_LZ(1'b1), .MAG_W(27)) dut (
    .clk_i(clk_i), .rst(rst), .value_i(value1), .valid_i(valid1),
    .ready_o(ready1), .num_o(num1), .done_o(done1), .ovf_o(ovf1)
  );

  seg7_bin2bcd #(.BLANK_LZ(1'b0), .MAG_W(27)) dut0 (
    .clk_i(clk_i), .rst(rst), .value_i(value0), .valid_i(valid0),
    .ready_o(ready0), .num_o(num0), .done_o(done0), .ovf_o(ovf0)
  );

  // Reference: {ovf, word} from decimal arithmetic on the signed value.
  function automatic logic [32:0] model(input logic [31:0] v, input bit blz);
    longint sv, mag;
    bit     neg;
    int     d[8];
    int     top;
    logic [31:0] w;
    sv = longint'($signed(v));
    if (sv > 64'sd99999999 || sv < -64'sd9999999) return {1'b1, 32'hFFFF_FFFF};
    neg = (sv < 0);
    mag = neg ? -sv : sv;
    top = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = int'(mag % 10);
      mag  = mag / 10;
      if (d[i] != 0) top = i;
    end
    w = '0;
    for (int i = 0; i < 8; i++) begin
      if (blz && i > top) w[i*4 +: 4] = 4'hA;
      else                w[i*4 +: 4] = 4'(d[i]);
    end
    if (neg) begin
      if (blz) w[(top+1)*4 +: 4] = 4'hF;
      else     w[31:28] = 4'hF;
    end
    return {1'b0, w};
  endfunction

  function automatic logic [31:0] rand_value();
    logic [31:0] r;
    case ($urandom_range(0, 4))
      0: r = $urandom;
      1: r = 32'($urandom_range(0, 99999999));
      2: r = -32'($urandom_range(1, 9999999));
      3: r = 32'($urandom_range(0, 999));
      default: r = 32'($urandom_range(99999990, 100000010));
    endcase
    return r;
  endfunction

  // Drive one conversion (instance ready) and return result and latency.
  task automatic run(input bit lz0, input logic [31:0] v,
                     output logic [31:0] w, output logic o, output int lat);
    if (lz0) begin value0 = v; valid0 = 1'b1; end
    else     begin value1 = v; valid1 = 1'b1; end
    @(posedge clk_i); #1;
    valid0 = 1'b0; valid1 = 1'b0;
    value0 = $urandom; value1 = $urandom;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk_i); #1;
      if ((lz0 ? done0 : done1) === 1'b1) begin lat = c; break; end
    end
    w = lz0 ? num0 : num1;
    o = lz0 ? ovf0 : ovf1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid1 = 1'b1; valid0 = 1'b1; value1 = 32'd55; value0 = 32'd55;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (num1 !== 32'hAAAA_AAAA) begin failures++; $display("FAIL reset_num got=%h exp=%h", num1, 32'hAAAA_AAAA); end
    checks++; if (num0 !== 32'hAAAA_AAAA) begin failures++; $display("FAIL reset_num0 got=%h exp=%h", num0, 32'hAAAA_AAAA); end
    checks++; if ({done1, ovf1, done0, ovf0} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {done1, ovf1, done0, ovf0}); end
    checks++; if ({ready1, ready0} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {ready1, ready0}); end
    rst = 1'b0; valid1 = 1'b0; valid0 = 1'b0;
    @(posedge clk_i); #1;
    checks++; if ({ready1, ready0} !== 2'b11) begin failures++; $display("FAIL ready_after_reset got=%b exp=11", {ready1, ready0}); end
  endtask

  task automatic test_latency();
    int lat, rdy_bad;
    value1 = 32'd1234; valid1 = 1'b1;
    @(posedge clk_i); #1;
    valid1 = 1'b0; value1 = $urandom;
    lat = 0; rdy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_i); #1;
      if (done1 === 1'b1) begin lat = c; break; end
      if (ready1 !== 1'b0) rdy_bad++;
    end
    checks++; if (lat != 29) begin failures++; $display("FAIL latency got=%0d exp=29", lat); end
    checks++; if (rdy_bad != 0) begin failures++; $display("FAIL busy_ready got=%0d high cycles exp=0", rdy_bad); end
    checks++; if (num1 !== 32'hAAAA_1234) begin failures++; $display("FAIL num_1234 got=%h exp=%h", num1, 32'hAAAA_1234); end
    checks++; if (ovf1 !== 1'b0) begin failures++; $display("FAIL ovf_1234 got=%b exp=0", ovf1); end
    checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL ready_at_done got=%b exp=1", ready1); end
    @(posedge clk_i); #1;
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", done1); end
    checks++; if (num1 !== 32'hAAAA_1234) begin failures++; $display("FAIL num_hold got=%h exp=%h", num1, 32'hAAAA_1234); end
  endtask

  task automatic test_values();
    logic [31:0] dir [8];
    logic [31:0] v, w;
    logic [32:0] e;
    logic o;
    int lat;
    dir[0] = -32'sd5;        dir[1] = 32'd0;          dir[2] = -32'sd9999999;  dir[3] = 32'd99999999;
    dir[4] = 32'd100000000;  dir[5] = -32'sd10000000; dir[6] = 32'h8000_0000;  dir[7] = 32'h7FFF_FFFF;
    for (int i = 0; i < 48; i++) begin
      v = (i < 8) ? dir[i] : rand_value();
      e = model(v, 1'b1);
      run(1'b0, v, w, o, lat);
      checks++; if (w !== e[31:0] || o !== e[32] || lat != 29) begin
        failures++;
        $display("FAIL blz1_value v=%0d got num=%h ovf=%b lat=%0d exp num=%h ovf=%b lat=29", $signed(v), w, o, lat, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_blank_lz0();
    logic [31:0] v, w;
    logic [32:0] e;
    logic o;
    int lat;
    run(1'b1, -32'sd42, w, o, lat);
    checks++; if (w !== 32'hF000_0042 || o !== 1'b0) begin failures++; $display("FAIL lz0_minus42 got=%h ovf=%b exp=%h ovf=0", w, o, 32'hF000_0042); end
    run(1'b1, 32'd7, w, o, lat);
    checks++; if (w !== 32'h0000_0007 || o !== 1'b0) begin failures++; $display("FAIL lz0_7 got=%h ovf=%b exp=%h ovf=0", w, o, 32'h0000_0007); end
    for (int i = 0; i < 24; i++) begin
      v = rand_value();
      e = model(v, 1'b0);
      run(1'b1, v, w, o, lat);
      checks++; if (w !== e[31:0] || o !== e[32] || lat != 29) begin
        failures++;
        $display("FAIL lz0_value v=%0d got num=%h ovf=%b lat=%0d exp num=%h ovf=%b lat=29", $signed(v), w, o, lat, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done, done_at, lat;
    value1 = 32'd12345678; valid1 = 1'b1;
    @(posedge clk_i); #1;
    valid1 = 1'b0;
    n_done = 0; done_at = 0;
    for (int c = 1; c <= 29; c++) begin
      @(posedge clk_i); #1;
      valid1 = 1'b0;
      if (done1 === 1'b1) begin n_done++; done_at = c; end
      if (c == 6) begin value1 = 32'd5; valid1 = 1'b1; end
    end
    checks++; if (n_done != 1 || done_at != 29) begin failures++; $display("FAIL busy_done got count=%0d at=%0d exp count=1 at=29", n_done, done_at); end
    checks++; if (num1 !== 32'h1234_5678) begin failures++; $display("FAIL busy_num got=%h exp=%h", num1, 32'h1234_5678); end
    // Next request presented in the done cycle.
    value1 = 32'd87654321; valid1 = 1'b1;
    @(posedge clk_i); #1;
    valid1 = 1'b0; value1 = $urandom;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_i); #1;
      if (done1 === 1'b1) begin lat = c; break; end
    end
    checks++; if (lat != 29 || num1 !== 32'h8765_4321) begin failures++; $display("FAIL b2b got num=%h lat=%0d exp num=%h lat=29", num1, lat, 32'h8765_4321); end
    n_done = 0;
    repeat (35) begin @(posedge clk_i); #1; if (done1 === 1'b1) n_done++; end
    checks++; if (n_done != 0) begin failures++; $display("FAIL spurious_done got=%0d exp=0", n_done); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    logic o;
    int lat, n_done;
    run(1'b0, 32'd100000000, w, o, lat);
    checks++; if (o !== 1'b1 || w !== 32'hFFFF_FFFF) begin failures++; $display("FAIL pre_ovf got num=%h ovf=%b exp num=ffffffff ovf=1", w, o); end
    value1 = 32'd12345678; valid1 = 1'b1;
    @(posedge clk_i); #1;
    valid1 = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    rst = 1'b1; valid1 = 1'b1; value1 = 32'd3;
    @(posedge clk_i); #1;
    checks++; if (num1 !== 32'hAAAA_AAAA || done1 !== 1'b0 || ovf1 !== 1'b0 || ready1 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got num=%h done=%b ovf=%b ready=%b exp num=aaaaaaaa done=0 ovf=0 ready=0", num1, done1, ovf1, ready1);
    end
    @(posedge clk_i); #1;
    checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL ready_in_reset got=%b exp=0", ready1); end
    rst = 1'b0; valid1 = 1'b0;
    n_done = 0;
    repeat (35) begin @(posedge clk_i); #1; if (done1 === 1'b1) n_done++; end
    checks++; if (n_done != 0 || num1 !== 32'hAAAA_AAAA) begin failures++; $display("FAIL after_reset got done_count=%0d num=%h exp done_count=0 num=aaaaaaaa", n_done, num1); end
    run(1'b0, 32'd7, w, o, lat);
    checks++; if (w !== 32'hAAAA_AAA7 || o !== 1'b0 || lat != 29) begin failures++; $display("FAIL post_reset_7 got num=%h ovf=%b lat=%0d exp num=aaaaaaa7 ovf=0 lat=29", w, o, lat); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_blank_lz0();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
